fetch_sequencer: RTL

Control-side driver for the 4-bit `Counter` program-address register in the fetch stage. It issues the counter's `value`/`operation`/`enable` controls and consumes its `count_out`. It steps instruction-fetch addresses from 0 to `LAST_ADDR` and presents each address to the fetch stage with a valid/stall handshake. It also handles branch redirects and single-step rewinds, then signals completion.

---
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer, its program-address counter and the fetch stage.
interface fetch_sequencer_if;
    logic       start;
    logic       stall;
    logic       branch_valid;
    logic [3:0] branch_target;
    logic       step_back;
    logic [3:0] count_in;
    logic [3:0] counter_value;
    logic [1:0] counter_op;
    logic       counter_enable;
    logic [3:0] fetch_addr;
    logic       fetch_valid;
    logic       busy;
    logic       done;

    modport master (
        input  start, stall, branch_valid, branch_target, step_back, count_in,
        output counter_value, counter_op, counter_enable, fetch_addr, fetch_valid, busy, done
    );

    modport slave (
        output start, stall, branch_valid, branch_target, step_back, count_in,
        input  counter_value, counter_op, counter_enable, fetch_addr, fetch_valid, busy, done
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Drives the 4-bit program-address counter through a fetch run from 0 to LAST_ADDR,
// handling stalls, branch redirects and single-step rewinds.
module fetch_sequencer #(
    parameter logic [3:0] LAST_ADDR = 4'd15
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_HOLD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    state_t state_q;
    state_t state_d;

    // Counter controls, handshake outputs and next state decoded from state and inputs.
    always_comb begin
        state_d            = state_q;
        bus.counter_enable = 1'b0;
        bus.counter_op     = OP_HOLD;
        bus.counter_value  = 4'd0;
        bus.fetch_valid    = 1'b0;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                bus.counter_enable = 1'b1;
                bus.busy           = 1'b1;
                if (bus.branch_valid) begin
                    bus.counter_op    = OP_LOAD;
                    bus.counter_value = bus.branch_target;
                end else if (bus.step_back) begin
                    // Rewinding from address 0 holds instead of wrapping to 15.
                    if (bus.count_in != 4'd0) begin
                        bus.counter_op    = OP_DEC;
                        bus.counter_value = bus.count_in;
                    end else begin
                        bus.counter_op    = OP_HOLD;
                    end
                end else if (bus.stall) begin
                    bus.fetch_valid = 1'b1;
                end else begin
                    bus.fetch_valid = 1'b1;
                    if (bus.count_in == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        bus.counter_op    = OP_INC;
                        bus.counter_value = bus.count_in;
                    end
                end
            end
            DONE: begin
                bus.counter_enable = 1'b1;
                bus.done           = 1'b1;
                if (bus.start) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.fetch_addr = bus.count_in;

    // State register; reset returns to IDLE without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
